// File: rtl/btn_pkg.sv
// Shared types for the button event path: FSM state encoding and press counter width.
package btn_pkg;

    localparam int PRESS_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        HELD    = 2'd2
    } btn_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level; reusable for any board input.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic s1;

    // NOTE: non-blocking assignments so q takes the s1 value from the previous edge, giving two real stages.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            q  <= 1'b0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/button_event.sv
// Turns the debounced button level into registered press/release/long/repeat pulses,
// a held flag and a wrapping press counter.
module button_event
    import btn_pkg::*;
#(
    parameter int LONG_CYCLES   = 50000000,
    parameter int REPEAT_CYCLES = 10000000,
    parameter int CNT_W         = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   btn_db,
    output logic                   press_pulse,
    output logic                   release_pulse,
    output logic                   long_pulse,
    output logic                   repeat_pulse,
    output logic                   held,
    output logic [PRESS_CNT_W-1:0] press_count
);

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    logic             s2;
    btn_state_e       state;
    logic [CNT_W-1:0] cnt;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn_db),
        .q   (s2)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;
            held          <= 1'b0;
            press_count   <= '0;
        end else begin
            // NOTE: pulses default low every edge so each fires for exactly one cycle.
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (s2) begin
                        state       <= PRESSED;
                        held        <= 1'b1;
                        press_pulse <= 1'b1;
                        cnt         <= '0;
                        press_count <= press_count + PRESS_CNT_W'(1);
                    end
                end
                // Release is tested first so it always beats a threshold on the same edge.
                PRESSED: begin
                    if (!s2) begin
                        state         <= IDLE;
                        held          <= 1'b0;
                        release_pulse <= 1'b1;
                    end else if (cnt == LONG_LAST) begin
                        state      <= HELD;
                        long_pulse <= 1'b1;
                        cnt        <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                HELD: begin
                    if (!s2) begin
                        state         <= IDLE;
                        held          <= 1'b0;
                        release_pulse <= 1'b1;
                    end else if (REPEAT_CYCLES > 0) begin
                        if (cnt == REPEAT_LAST) begin
                            repeat_pulse <= 1'b1;
                            cnt          <= '0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    held  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_event.sv
// Scoreboard bench: stimulus pushes expected pulses with their edge numbers, monitors pop and compare.
module tb_button_event;

    localparam int L = 8;
    localparam int R = 4;

    typedef enum int {EV_PRESS = 0, EV_RELEASE = 1, EV_LONG = 2, EV_REPEAT = 3} ev_kind_e;
    typedef struct {
        ev_kind_e kind;
        int       edge_n;
        int       pcount;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_a = 1'b0;
    logic       btn_b = 1'b0;
    logic       pa, ra, la, rpa, ha;
    logic       pb, rb, lb, rpb, hb;
    logic [7:0] pca, pcb;

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    ev_t  qa[$];
    ev_t  qb[$];
    int   held_a_total = 0, held_b_total = 0;
    int   press_a_total = 0, release_a_total = 0, repeat_b_total = 0;

    button_event #(.LONG_CYCLES(L), .REPEAT_CYCLES(R), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .btn_db(btn_a),
        .press_pulse(pa), .release_pulse(ra), .long_pulse(la), .repeat_pulse(rpa),
        .held(ha), .press_count(pca)
    );

    button_event #(.LONG_CYCLES(L), .REPEAT_CYCLES(0), .CNT_W(8)) dut_b (
        .clk(clk), .rst(rst), .btn_db(btn_b),
        .press_pulse(pb), .release_pulse(rb), .long_pulse(lb), .repeat_pulse(rpb),
        .held(hb), .press_count(pcb)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_ev(input int which, input ev_kind_e k, input int e, input int pc);
        ev_t ev;
        ev.kind   = k;
        ev.edge_n = e;
        ev.pcount = pc;
        if (which == 0) qa.push_back(ev);
        else            qb.push_back(ev);
    endtask

    function automatic int qsize(input int which);
        return (which == 0) ? qa.size() : qb.size();
    endfunction

    task automatic qpop(input int which, output ev_t ev);
        if (which == 0) ev = qa.pop_front();
        else            ev = qb.pop_front();
    endtask

    function automatic int front_edge(input int which);
        return (which == 0) ? qa[0].edge_n : qb[0].edge_n;
    endfunction

    task automatic monitor_one(input int which, input string tag, input logic p, input logic r,
                               input logic l, input logic rp, input logic h, input logic [7:0] pc);
        int  n;
        int  kind;
        ev_t ev;
        n = int'(p) + int'(r) + int'(l) + int'(rp);
        while (qsize(which) > 0 && front_edge(which) < cyc) begin
            qpop(which, ev);
            check({tag, " missed pulse kind ", ev.kind.name()}, cyc, ev.edge_n);
        end
        if (n > 0) begin
            check({tag, " pulses one-hot"}, n, 1);
            kind = p ? 0 : (r ? 1 : (l ? 2 : 3));
            if (qsize(which) == 0) begin
                check({tag, " unexpected pulse kind"}, kind, -1);
            end else begin
                qpop(which, ev);
                check({tag, " pulse kind"}, kind, int'(ev.kind));
                check({tag, " pulse edge"}, cyc, ev.edge_n);
                if (ev.kind == EV_PRESS) check({tag, " press_count"}, int'(pc), ev.pcount);
                check({tag, " held with pulse"}, int'(h), (ev.kind == EV_RELEASE) ? 0 : 1);
            end
        end
    endtask

    always @(negedge clk) begin
        monitor_one(0, "a", pa, ra, la, rpa, ha, pca);
        monitor_one(1, "b", pb, rb, lb, rpb, hb, pcb);
        if (ha)  held_a_total++;
        if (hb)  held_b_total++;
        if (pa)  press_a_total++;
        if (ra)  release_a_total++;
        if (rpb) repeat_b_total++;
    end

    initial begin
        int t0;
        int snap, snap2;

        // Reset held for 3 cycles with the button already down.
        btn_a = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("rst press_pulse", int'(pa), 0);
            check("rst release_pulse", int'(ra), 0);
            check("rst long_pulse", int'(la), 0);
            check("rst repeat_pulse", int'(rpa), 0);
            check("rst held", int'(ha), 0);
            check("rst press_count", int'(pca), 0);
        end
        t0 = cyc + 1;
        expect_ev(0, EV_PRESS, t0 + 2, 1);
        expect_ev(0, EV_RELEASE, t0 + 5, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        btn_a = 1'b0;
        repeat (6) @(negedge clk);

        // Short tap of 3 cycles.
        snap = held_a_total;
        t0 = cyc + 1;
        btn_a = 1'b1;
        expect_ev(0, EV_PRESS, t0 + 2, 2);
        expect_ev(0, EV_RELEASE, t0 + 5, 0);
        repeat (3) @(negedge clk);
        btn_a = 1'b0;
        repeat (6) @(negedge clk);
        check("tap held cycles", held_a_total - snap, 3);

        // Long hold of 20 cycles: repeat at t0+22 loses to release.
        t0 = cyc + 1;
        btn_a = 1'b1;
        expect_ev(0, EV_PRESS, t0 + 2, 3);
        expect_ev(0, EV_LONG, t0 + 10, 0);
        expect_ev(0, EV_REPEAT, t0 + 14, 0);
        expect_ev(0, EV_REPEAT, t0 + 18, 0);
        expect_ev(0, EV_RELEASE, t0 + 22, 0);
        repeat (20) @(negedge clk);
        btn_a = 1'b0;
        repeat (6) @(negedge clk);

        // Exactly 8 cycles: release at t0+10 wins over long_pulse.
        t0 = cyc + 1;
        btn_a = 1'b1;
        expect_ev(0, EV_PRESS, t0 + 2, 4);
        expect_ev(0, EV_RELEASE, t0 + 10, 0);
        repeat (8) @(negedge clk);
        btn_a = 1'b0;
        repeat (6) @(negedge clk);

        // Clear the counter, then 257 taps wrap it to 1.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("mid-run rst press_count", int'(pca), 0);
        rst = 1'b0;
        snap  = press_a_total;
        snap2 = release_a_total;
        for (int i = 0; i < 257; i++) begin
            t0 = cyc + 1;
            btn_a = 1'b1;
            expect_ev(0, EV_PRESS, t0 + 2, (i + 1) % 256);
            expect_ev(0, EV_RELEASE, t0 + 5, 0);
            repeat (3) @(negedge clk);
            btn_a = 1'b0;
            repeat (3) @(negedge clk);
        end
        repeat (4) @(negedge clk);
        check("wrap press_count", int'(pca), 1);
        check("wrap press pulses", press_a_total - snap, 257);
        check("wrap release pulses", release_a_total - snap2, 257);

        // REPEAT_CYCLES=0 build held for 40 cycles.
        snap  = held_b_total;
        snap2 = repeat_b_total;
        t0 = cyc + 1;
        btn_b = 1'b1;
        expect_ev(1, EV_PRESS, t0 + 2, 1);
        expect_ev(1, EV_LONG, t0 + 10, 0);
        expect_ev(1, EV_RELEASE, t0 + 42, 0);
        repeat (40) @(negedge clk);
        btn_b = 1'b0;
        repeat (6) @(negedge clk);
        check("norepeat held cycles", held_b_total - snap, 40);
        check("norepeat repeat pulses", repeat_b_total - snap2, 0);

        repeat (4) @(negedge clk);
        check("a scoreboard drained", qa.size(), 0);
        check("b scoreboard drained", qb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/button_event.md
Name: button_event

Overview:
- Downstream consumer of the debounced button level produced by the debounce stage.
- Resynchronises that level into the system clock domain; the debounce output is generated off the button itself, so it is asynchronous to `clk`.
- Converts the level into single-cycle event pulses: press, release, long-press and auto-repeat.
- Maintains a wrapping press counter and exposes a held-level flag for peripherals in the npc design.

Parameters:
- LONG_CYCLES, 50000000: cycles the button must stay held, counted from the press pulse, before `long_pulse` fires. Must be >= 2.
- REPEAT_CYCLES, 10000000: period of `repeat_pulse` after the long press. 0 disables auto-repeat.
- CNT_W, 32: width of the internal hold counter. Must hold max(LONG_CYCLES, REPEAT_CYCLES).

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- btn_db  input  1  debounced button level from the debounce stage; asynchronous to clk.
- press_pulse  output  1  one-cycle pulse on press.
- release_pulse  output  1  one-cycle pulse on release.
- long_pulse  output  1  one-cycle pulse when the hold reaches LONG_CYCLES.
- repeat_pulse  output  1  one-cycle pulse every REPEAT_CYCLES while in HELD.
- held  output  1  high while the FSM is in PRESSED or HELD.
- press_count  output  8  number of presses, wraps modulo 256.

Behaviour:
- Reset: one clock and a synchronous active-high reset, named clk and rst.
  - While rst=1 at a posedge: synchroniser flops=0, state=IDLE, hold counter=0.
  - All outputs go to 0, including press_count=0.
  - Reset mid-hold: no release_pulse is generated. After reset deasserts with btn_db still high, a fresh press_pulse occurs.
- Synchroniser: two flops, s1<=btn_db, s2<=s1. All FSM decisions at a posedge use the s2 value registered at the previous edge.
- All outputs are registered. Pulses are high for exactly one cycle.
- Latency: let edge t0 be the first edge that samples btn_db=1.
  - press_pulse is high in the cycle after edge t0+2.
  - Release latency from the first edge sampling 0 is likewise 2 edges.
- FSM states: IDLE, PRESSED, HELD.
  - IDLE, s2=1: go to PRESSED; press_pulse=1; cnt=0; press_count+=1.
  - PRESSED, s2=0: go to IDLE; release_pulse=1.
  - PRESSED, s2=1: cnt+=1. When cnt == LONG_CYCLES-1 at the edge, go to HELD, long_pulse=1, cnt=0. Result: long_pulse is registered at edge t0+2+LONG_CYCLES.
  - HELD, s2=0: go to IDLE; release_pulse=1.
  - HELD, s2=1, REPEAT_CYCLES>0: cnt+=1. When cnt == REPEAT_CYCLES-1, repeat_pulse=1 and cnt=0. Result: repeats at t0+2+LONG_CYCLES+k*REPEAT_CYCLES, for k>=1.
  - HELD, REPEAT_CYCLES=0: counter frozen, no repeats.
- Precedence: release beats long/repeat. If s2=0 on the edge where a threshold would fire, only release_pulse is produced.
- At most one of press/release/long/repeat is high in any cycle.
- held is registered with the state: 1 in PRESSED and HELD.
- press_count wraps 255 -> 0 with no flag.
- The hold counter never exceeds max(LONG_CYCLES, REPEAT_CYCLES)-1.
- A btn_db glitch shorter than one clk period may be missed. That is acceptable because the upstream stage is already debounced.

Decomposition:
- Package btn_pkg: the state enum (IDLE, PRESSED, HELD) and the press_count width constant (8).
- Sub-module sync_2ff (1-bit, two flops, synchronous reset to 0): the only natural split. It is reusable for other asynchronous board inputs.

Test Plan:
All cases use LONG_CYCLES=8, REPEAT_CYCLES=4, with t0 as defined above.
- Reset: hold rst=1 for 3 cycles with btn_db=1, then release rst. All outputs are 0 during reset; press_pulse fires 2 edges after the first non-reset sampling edge; press_count=1.
- Short tap: btn_db=1 for 3 cycles, then 0. Expect press at t0+2, release at t0+5, no long_pulse, held high for exactly 3 cycles.
- Long hold: btn_db=1 for 20 cycles. Expect press at t0+2, long at t0+10, repeats at t0+14 and t0+18, release at t0+22. The would-be repeat at t0+22 is suppressed by release.
- Boundary: btn_db=1 for exactly 8 cycles. Release at t0+10 wins over long_pulse, so long_pulse is never asserted.
- Wrap: 257 short taps give press_count = 1, and exactly 257 press and 257 release pulses.
- REPEAT_CYCLES=0 build: hold 40 cycles. Expect one long_pulse at t0+10, zero repeat_pulse, held=1 until release.
